pattern_scheduler: RTL

- Game-rhythm controller for the Finger Dancer note path.
- Owns the current 4-bit lane pattern and steps the external updatePattern generator once per beat.
- Scrolls generated patterns through a 4-row note queue and judges player key presses against the bottom row.
- Tracks score, misses and game state (idle/run/pause/over) for the display and top-level logic.

---
 rtl/pattern_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pattern_scheduler.sv
// Rhythm controller for the Finger Dancer note path: steps the pattern generator once per
// beat, scrolls a 4-row note queue and judges key presses against the bottom row.
module pattern_scheduler #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter logic [3:0]  MAX_MISS = 4'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic [3:0]  seed,
  input  logic [3:0]  pat_nxt,
  output logic [3:0]  pat_cur,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] lanes,
  output logic        beat,
  output logic        hit,
  output logic        miss,
  output logic [7:0]  score,
  output logic [3:0]  misses,
  output logic [1:0]  state,
  output logic        game_over
);

  localparam int unsigned   TW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    pat_q, pat_d;
  logic [15:0]   lanes_q, lanes_d;
  logic [7:0]    score_q, score_d;
  logic [3:0]    misses_q, misses_d;
  logic          beat_q, beat_d;
  logic          hit_q, hit_d;
  logic          miss_q, miss_d;
  logic          over_q, over_d;
  logic          active_s, beat_s, judged_s;
  logic [3:0]    row0_s;

  // Next-state logic: start handling, pause, beat timing, judging and expiry.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    pat_d    = pat_q;
    lanes_d  = lanes_q;
    score_d  = score_q;
    misses_d = misses_q;
    beat_d   = 1'b0;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    active_s = 1'b0;
    beat_s   = 1'b0;
    judged_s = 1'b0;
    row0_s   = lanes_q[3:0];

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d  = S_RUN;
          pat_d    = (seed == 4'd0) ? 4'b0001 : seed;
          lanes_d  = 16'd0;
          score_d  = 8'd0;
          misses_d = 4'd0;
          tick_d   = '0;
        end else begin
          state_d = state_q;
        end
      end
      // A PAUSE cycle with pause low already plays, so a beat slips by exactly the paused cycles.
      S_RUN, S_PAUSE: begin
        if (pause) begin
          state_d = S_PAUSE;
        end else begin
          state_d  = S_RUN;
          active_s = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (active_s) begin
      beat_s   = (tick_q == TICK_LAST);
      tick_d   = beat_s ? '0 : tick_q + TW'(1);
      judged_s = key_valid && (row0_s != 4'd0);
      if (judged_s) begin
        if (key_code == row0_s) begin
          hit_d   = 1'b1;
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
        end else begin
          miss_d = 1'b1;
        end
        lanes_d[3:0] = 4'd0;
      end else if (beat_s && (row0_s != 4'd0)) begin
        miss_d = 1'b1;
      end else begin
        miss_d = 1'b0;
      end
      // Judging sees the pre-shift bottom row; the shift then discards it.
      if (beat_s) begin
        beat_d  = 1'b1;
        lanes_d = {pat_q, lanes_q[15:4]};
        pat_d   = pat_nxt;
      end else begin
        beat_d = 1'b0;
      end
      if (miss_d) begin
        misses_d = (misses_q >= MAX_MISS) ? MAX_MISS : misses_q + 4'd1;
        if (misses_d == MAX_MISS) begin
          state_d = S_OVER;
        end else begin
          state_d = state_d;
        end
      end else begin
        misses_d = misses_q;
      end
    end else begin
      tick_d = tick_d;
    end

    over_d = (state_d == S_OVER);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      pat_q    <= 4'd0;
      lanes_q  <= 16'd0;
      score_q  <= 8'd0;
      misses_q <= 4'd0;
      beat_q   <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      pat_q    <= pat_d;
      lanes_q  <= lanes_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      beat_q   <= beat_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      over_q   <= over_d;
    end
  end

  assign pat_cur   = pat_q;
  assign lanes     = lanes_q;
  assign beat      = beat_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign state     = state_q;
  assign game_over = over_q;

endmodule
